// File: rtl/pc_unit.sv
// Program counter for a word-addressed instruction memory. It steps through the
// IDLE/RUN/HALT/ERROR states and selects the next pc from the redirect inputs by priority.
module pc_unit #(
    parameter int MEM_DEPTH = 256,
    parameter int RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_addr,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic [1:0]  state,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    localparam logic [9:0]  RESET_PC_W = 10'(RESET_PC);
    localparam logic [10:0] DEPTH_W    = 11'(MEM_DEPTH);

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_pc, w_pc_nxt, w_pc_plus1, w_target;
    logic [15:0] r_fcnt, w_fcnt_nxt;
    logic        w_jr_bad, w_bad_target;
    logic        w_unused_bits;

    assign w_unused_bits = ^{jump_addr[25:10], branch_offset[15:10]};

    assign w_pc_plus1 = r_pc + 10'd1;

    // The sum is truncated to 10 bits, so only the low 10 bits of the sign-extended
    // offset can affect the result.
    always_comb begin
        w_target = w_pc_plus1;
        w_jr_bad = 1'b0;
        if (jr) begin
            w_target = jr_addr[9:0];
            w_jr_bad = |jr_addr[31:10];
        end else if (jump) begin
            w_target = jump_addr[9:0];
        end else if (branch_taken) begin
            w_target = w_pc_plus1 + branch_offset[9:0];
        end
    end

    assign w_bad_target = w_jr_bad || ({1'b0, w_target} >= DEPTH_W);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (stall) begin
                    w_state_nxt = S_RUN;
                end else if (w_bad_target) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_pc_nxt   = w_target;
                    w_fcnt_nxt = (r_fcnt == 16'hFFFF) ? r_fcnt : r_fcnt + 16'd1;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC_W;
            r_fcnt  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    assign pc          = {22'd0, r_pc};
    assign pc_plus1    = {22'd0, w_pc_plus1};
    assign state       = r_state;
    assign fetch_count = r_fcnt;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit. Directed scenarios and random stimulus are compared against
// an integer-arithmetic reference model of the fetch sequencer.
module tb_pc_unit;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, halt_req, branch_taken, jump, jr;
    logic [15:0] branch_offset;
    logic [25:0] jump_addr;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus1;
    logic [1:0]  state;
    logic [15:0] fetch_count;

    int n_chk  = 0;
    int n_fail = 0;
    int m_pc, m_st, m_fc;

    pc_unit #(.MEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_addr(jump_addr), .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus1(pc_plus1),
        .state(state), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model. States: 0 idle, 1 run, 2 halt, 3 error.
    task automatic model_edge();
        int  tgt;
        bit  bad;
        if (!rst_n) begin
            m_pc = 0; m_st = 0; m_fc = 0;
        end else if (m_st == 0) begin
            if (start) m_st = 1;
        end else if (m_st == 1 && !halt_req && !stall) begin
            bad = 0;
            if (jr) begin
                if (jr_addr >= 32'd1024) bad = 1;
                tgt = int'(jr_addr % 32'd1024);
            end else if (jump) begin
                tgt = int'(jump_addr) % 1024;
            end else if (branch_taken) begin
                tgt = ((m_pc + 1 + int'($signed(branch_offset))) % 1024 + 1024) % 1024;
            end else begin
                tgt = (m_pc + 1) % 1024;
            end
            if (bad || tgt >= DEPTH) begin
                m_st = 3;
            end else begin
                m_pc = tgt;
                if (m_fc < 65535) m_fc = m_fc + 1;
            end
        end else if (m_st == 1 && halt_req) begin
            m_st = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", pc, m_pc);
        chk("state", {30'd0, state}, m_st);
        chk("fetch_count", {16'd0, fetch_count}, m_fc);
        chk("pc_plus1", pc_plus1, (m_pc + 1) % 1024);
    endtask

    task automatic quiet();
        start = 0; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_offset = 16'd0; jump_addr = 26'd0; jr_addr = 32'd0;
    endtask

    task automatic reset_and_start();
        quiet(); rst_n = 0; tick();
        rst_n = 1; start = 1; tick();
        start = 0;
    endtask

    task automatic jump_to(input int a);
        jump = 1; jump_addr = 26'(a); tick();
        jump = 0;
    endtask

    initial begin
        quiet();
        rst_n = 0;
        tick();
        chk("reset_pc", pc, 32'd0);
        chk("reset_state", {30'd0, state}, 32'd0);

        // start ignored while reset held; accepted first edge after release
        start = 1; tick();
        chk("start_in_reset", {30'd0, state}, 32'd0);
        rst_n = 1; tick();
        chk("start_accept", {30'd0, state}, 32'd1);
        chk("start_pc_hold", pc, 32'd0);
        start = 0;

        for (int i = 0; i < 5; i++) tick();
        chk("seq_pc5", pc, 32'd5);
        chk("seq_fc5", {16'd0, fetch_count}, 32'd5);
        chk("seq_run", {30'd0, state}, 32'd1);

        for (int i = 0; i < 5; i++) tick();
        branch_taken = 1; branch_offset = 16'hFFFB; tick();
        chk("branch_back", pc, 32'd6);
        branch_taken = 0;
        for (int i = 0; i < 4; i++) tick();
        branch_taken = 1; branch_offset = 16'h0004; tick();
        chk("branch_fwd", pc, 32'd15);
        branch_taken = 0;

        stall = 1; jump = 1; jump_addr = 26'h3FF_0040; tick();
        chk("stall_jump_hold", pc, 32'd15);
        stall = 0; tick();
        chk("jump_low_bits", pc, 32'd64);
        jump = 0;

        jr = 1; jr_addr = 32'h0000_0400; tick();
        chk("jr_hi_err", {30'd0, state}, 32'd3);
        chk("jr_hi_pc", pc, 32'd64);
        jr = 0; start = 1; tick();
        chk("err_sticky", {30'd0, state}, 32'd3);

        reset_and_start();
        jr = 1; jr_addr = 32'h0000_0100; tick();
        chk("jr_depth_err", {30'd0, state}, 32'd3);
        chk("jr_depth_pc", pc, 32'd0);

        reset_and_start();
        jump_to(20);
        halt_req = 1; jr = 1; jr_addr = 32'd5; tick();
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_pc", pc, 32'd20);
        quiet(); start = 1; tick(); tick();
        chk("halt_sticky", {30'd0, state}, 32'd2);
        chk("halt_sticky_pc", pc, 32'd20);

        reset_and_start();
        jump_to(DEPTH - 1);
        tick();
        chk("inc_past_depth", {30'd0, state}, 32'd3);
        chk("inc_past_depth_pc", pc, DEPTH - 1);

        reset_and_start();
        branch_taken = 1; branch_offset = 16'hFFFE; tick();
        chk("branch_wrap_err", {30'd0, state}, 32'd3);

        reset_and_start();
        jump_to(30);
        branch_taken = 1; branch_offset = 16'd3; rst_n = 0; tick();
        chk("midrun_rst_pc", pc, 32'd0);
        chk("midrun_rst_state", {30'd0, state}, 32'd0);
        chk("midrun_rst_fc", {16'd0, fetch_count}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int t;
            rst_n        = ($urandom_range(0, 99) >= 3);
            start        = ($urandom_range(0, 3) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            halt_req     = ($urandom_range(0, 59) == 0);
            jr           = ($urandom_range(0, 9) == 0);
            jr_addr      = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 300));
            jump         = ($urandom_range(0, 9) == 0);
            jump_addr    = {16'($urandom), 10'($urandom_range(0, 270))};
            branch_taken = ($urandom_range(0, 5) == 0);
            t            = $urandom_range(0, 40);
            branch_offset = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(t - 20);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
